// File: rtl/rv_pkg.sv
// rv_pkg - shared register-file definitions for the RV32I core.
//   REG_DATA_WIDTH_DEF : default register width
//   REG_COUNT_DEF      : default architectural register count
//   REG_ZERO           : index of the hard-wired zero register
//   reg_idx_t          : register index type for the default register count
package rv_pkg;

   localparam int unsigned REG_DATA_WIDTH_DEF = 32;
   localparam int unsigned REG_COUNT_DEF      = 32;
   localparam int unsigned REG_ZERO           = 0;

   typedef logic [$clog2(REG_COUNT_DEF)-1:0] reg_idx_t;

endpackage

// File: rtl/gpregs_rdport.sv
// gpregs_rdport - one combinational read port of the register file.
//   rd_idx_i   : register index to read
//   regs_i     : flattened register contents, entry 0 tied to zero
//   busy_i     : scoreboard bits, bit 0 tied to zero
//   wr_vld_i   : a legal write-back is happening this cycle
//   wr_idx_i   : write-back index
//   wr_data_i  : write-back data
//   iss_vld_i  : a legal issue is happening this cycle
//   iss_idx_i  : issue destination index
//   rd_data_o  : read data (0 for index 0 or out-of-range index)
//   rd_busy_o  : outstanding-write flag for the read index
module gpregs_rdport
   import rv_pkg::*;
#(
   parameter int DW     = 32,
   parameter int COUNT  = 32,
   parameter int AW     = 5,
   parameter int BYPASS = 1
) (
   input  logic [AW-1:0]       rd_idx_i,
   input  logic [COUNT*DW-1:0] regs_i,
   input  logic [COUNT-1:0]    busy_i,
   input  logic                wr_vld_i,
   input  logic [AW-1:0]       wr_idx_i,
   input  logic [DW-1:0]       wr_data_i,
   input  logic                iss_vld_i,
   input  logic [AW-1:0]       iss_idx_i,
   output logic [DW-1:0]       rd_data_o,
   output logic                rd_busy_o
);

   always_comb begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
      // Indices at or above COUNT never match, so they fall through as zero.
      for (int i = 0; i < COUNT; i++) begin
         if (32'(rd_idx_i) == 32'(i)) begin
            rd_data_o = regs_i[i*DW +: DW];
            rd_busy_o = busy_i[i];
         end
      end
      // wr_vld_i already excludes x0 and out-of-range indices. A write that
      // lands this cycle retires the producer unless a new one issues to the
      // same register in the same cycle.
      if ((BYPASS != 0) && wr_vld_i && (rd_idx_i == wr_idx_i)) begin
         rd_data_o = wr_data_i;
         rd_busy_o = iss_vld_i && (iss_idx_i == rd_idx_i);
      end
      if (rd_idx_i == AW'(REG_ZERO)) begin
         rd_data_o = '0;
         rd_busy_o = 1'b0;
      end
   end

endmodule

// File: rtl/gpregs_sb.sv
// gpregs_sb - general-purpose register file with write-pending scoreboard.
//   clk          : clock, all state changes on rising edge
//   cpurst       : synchronous active-high reset (clears data and busy bits)
//   read_reg     : READ_PORTS packed read indices
//   dout_reg     : READ_PORTS packed read data
//   dout_busy    : per-port outstanding-write flag
//   write_reg    : write-back index
//   din          : write-back data
//   din_enable   : write-back strobe (also clears the busy bit)
//   issue_reg    : destination of the instruction being issued
//   issue_enable : issue strobe (sets the busy bit)
//   busy_vec     : raw scoreboard, bit 0 always 0
module gpregs_sb
   import rv_pkg::*;
#(
   parameter int REG_DATA_WIDTH = int'(REG_DATA_WIDTH_DEF),
   parameter int REG_COUNT      = int'(REG_COUNT_DEF),
   parameter int REG_ADDR_WIDTH = $clog2(REG_COUNT),
   parameter int READ_PORTS     = 2,
   parameter int BYPASS         = 1
) (
   input  logic                                 clk,
   input  logic                                 cpurst,
   input  logic [READ_PORTS*REG_ADDR_WIDTH-1:0] read_reg,
   output logic [READ_PORTS*REG_DATA_WIDTH-1:0] dout_reg,
   output logic [READ_PORTS-1:0]                dout_busy,
   input  logic [REG_ADDR_WIDTH-1:0]            write_reg,
   input  logic [REG_DATA_WIDTH-1:0]            din,
   input  logic                                 din_enable,
   input  logic [REG_ADDR_WIDTH-1:0]            issue_reg,
   input  logic                                 issue_enable,
   output logic [REG_COUNT-1:0]                 busy_vec
);

   logic [REG_DATA_WIDTH-1:0]           regs_q [1:REG_COUNT-1];
   logic [REG_COUNT-1:1]                busy_q, busy_d;
   logic [REG_COUNT*REG_DATA_WIDTH-1:0] regs_flat;
   logic                                wr_vld, iss_vld;

   function automatic logic idx_ok(input logic [REG_ADDR_WIDTH-1:0] idx);
      return (idx != REG_ADDR_WIDTH'(REG_ZERO)) && (32'(idx) < 32'(REG_COUNT));
   endfunction

   assign wr_vld  = din_enable   && idx_ok(write_reg);
   assign iss_vld = issue_enable && idx_ok(issue_reg);

   // Clear for the retiring producer first, then set for the new one, so a
   // same-index issue and write-back leaves the register busy.
   always_comb begin
      busy_d = busy_q;
      for (int i = 1; i < REG_COUNT; i++) begin
         if (wr_vld && (write_reg == REG_ADDR_WIDTH'(i))) busy_d[i] = 1'b0;
         if (iss_vld && (issue_reg == REG_ADDR_WIDTH'(i))) busy_d[i] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (cpurst) begin
         for (int i = 1; i < REG_COUNT; i++) regs_q[i] <= '0;
         busy_q <= '0;
      end else begin
         for (int i = 1; i < REG_COUNT; i++) begin
            if (wr_vld && (write_reg == REG_ADDR_WIDTH'(i))) regs_q[i] <= din;
         end
         busy_q <= busy_d;
      end
   end

   assign busy_vec = {busy_q, 1'b0};

   assign regs_flat[REG_DATA_WIDTH-1:0] = '0;
   for (genvar g = 1; g < REG_COUNT; g++) begin : g_flat
      assign regs_flat[g*REG_DATA_WIDTH +: REG_DATA_WIDTH] = regs_q[g];
   end

   for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
      gpregs_rdport #(
         .DW     (REG_DATA_WIDTH),
         .COUNT  (REG_COUNT),
         .AW     (REG_ADDR_WIDTH),
         .BYPASS (BYPASS)
      ) u_rdport (
         .rd_idx_i  (read_reg[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]),
         .regs_i    (regs_flat),
         .busy_i    (busy_vec),
         .wr_vld_i  (wr_vld),
         .wr_idx_i  (write_reg),
         .wr_data_i (din),
         .iss_vld_i (iss_vld),
         .iss_idx_i (issue_reg),
         .rd_data_o (dout_reg[p*REG_DATA_WIDTH +: REG_DATA_WIDTH]),
         .rd_busy_o (dout_busy[p])
      );
   end

endmodule
